// File: rtl/reaction_pkg.sv
// reaction_pkg: shared definitions for the reaction timer result path.
//   Timer state / fail codes, message length, ASCII constants, fixed
//   message strings, the reader FSM encoding and a helper that picks one
//   character of the result message.
package reaction_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RANDOM = 2'd1,
      ST_REACT  = 2'd2,
      ST_DONE   = 2'd3
   } timer_state_e;

   typedef enum logic [1:0] {
      FAIL_NONE  = 2'd0,
      FAIL_EARLY = 2'd1,
      FAIL_SLOW  = 2'd2,
      FAIL_RSVD  = 2'd3
   } fail_code_e;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_SEND = 1'b1
   } rd_state_e;

   localparam int MSG_LEN = 5;

   localparam logic [7:0] ASCII_0   = 8'h30;
   localparam logic [7:0] ASCII_DOT = 8'h2E;
   localparam logic [7:0] ASCII_QM  = 8'h3F;

   // First character sits in the most significant byte.
   localparam logic [39:0] MSG_EARLY = "EARLY";
   localparam logic [39:0] MSG_SLOW  = "SLOW!";
   localparam logic [39:0] MSG_UNK   = "?????";

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      digit_char = (d > 4'd9) ? ASCII_QM : (ASCII_0 + {4'd0, d});
   endfunction

   // Character idx (0..4) of the message for a latched code and digits
   // {d3,d2,d1,d0}.
   function automatic logic [7:0] msg_char(input logic [1:0]  code,
                                           input logic [15:0] digits,
                                           input logic [2:0]  idx);
      logic [39:0] s;
      case (code)
         FAIL_NONE:  s = {digit_char(digits[15:12]), ASCII_DOT,
                          digit_char(digits[11:8]), digit_char(digits[7:4]),
                          digit_char(digits[3:0])};
         FAIL_EARLY: s = MSG_EARLY;
         FAIL_SLOW:  s = MSG_SLOW;
         default:    s = MSG_UNK;
      endcase
      case (idx)
         3'd0:    msg_char = s[39:32];
         3'd1:    msg_char = s[31:24];
         3'd2:    msg_char = s[23:16];
         3'd3:    msg_char = s[15:8];
         default: msg_char = s[7:0];
      endcase
   endfunction

endpackage

// File: rtl/bcd4_to_bin.sv
// bcd4_to_bin: combinational 4-digit BCD to 14-bit binary.
//   i_d3..i_d0 : BCD digits, i_d3 most significant (thousands)
//   o_bin      : i_d3*1000 + i_d2*100 + i_d1*10 + i_d0 (0..9999)
// Any digit above 9 is counted as 9 so the result never exceeds 9999.
module bcd4_to_bin (
   input  logic [3:0]  i_d3,
   input  logic [3:0]  i_d2,
   input  logic [3:0]  i_d1,
   input  logic [3:0]  i_d0,
   output logic [13:0] o_bin
);

   function automatic logic [13:0] clamp9(input logic [3:0] d);
      clamp9 = (d > 4'd9) ? 14'd9 : {10'd0, d};
   endfunction

   always_comb begin
      o_bin = clamp9(i_d3) * 14'd1000 + clamp9(i_d2) * 14'd100
            + clamp9(i_d1) * 14'd10   + clamp9(i_d0);
   end

endmodule

// File: rtl/reaction_result_reader.sv
// reaction_result_reader: captures each finished reaction-timer round and
// streams a 5-character ASCII result message over valid/ready.
//   i_clk, i_reset_n       : clock, async active-low reset
//   i_state, i_fail_state  : timer state and result code
//   i_seg3..i_seg0         : BCD reading (seg3 = seconds, seg0 = ms)
//   i_char_ready           : sink accepts o_char
//   o_char_valid/o_char/o_char_last : character stream, last = 5th char
//   o_busy                 : message pending or in flight
//   o_result_ms/o_result_code : last captured result
//   o_attempts             : saturating capture count
//   o_best_ms/o_best_valid : best successful time
// Build option: define REACTION_BEST_TIME_EN to build the best-time record;
// otherwise o_best_ms / o_best_valid are constant 0.
module reaction_result_reader
   import reaction_pkg::*;
#(
   parameter int ATTEMPT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic [1:0]           i_state,
   input  logic [1:0]           i_fail_state,
   input  logic [3:0]           i_seg3,
   input  logic [3:0]           i_seg2,
   input  logic [3:0]           i_seg1,
   input  logic [3:0]           i_seg0,
   input  logic                 i_char_ready,
   output logic                 o_char_valid,
   output logic [7:0]           o_char,
   output logic                 o_char_last,
   output logic                 o_busy,
   output logic [13:0]          o_result_ms,
   output logic [1:0]           o_result_code,
   output logic [ATTEMPT_W-1:0] o_attempts,
   output logic [13:0]          o_best_ms,
   output logic                 o_best_valid
);

   rd_state_e             rd_state_q, rd_state_d;
   logic [1:0]            prev_state_q, prev_state_d;
   logic [2:0]            idx_q, idx_d;
   logic [15:0]           digits_q, digits_d;
   logic [1:0]            code_q, code_d;
   logic [13:0]           result_ms_q, result_ms_d;
   logic [ATTEMPT_W-1:0]  attempts_q, attempts_d;
   logic [13:0]           live_ms;
   logic                  capture;
   logic                  accept;
   logic                  xfer;

   bcd4_to_bin u_bcd (
      .i_d3  (i_seg3),
      .i_d2  (i_seg2),
      .i_d1  (i_seg1),
      .i_d0  (i_seg0),
      .o_bin (live_ms)
   );

   // Rising into done; ignored while a message is still being sent.
   assign capture = (i_state == ST_DONE) && (prev_state_q != ST_DONE);
   assign accept  = capture && (rd_state_q == RD_IDLE);
   assign xfer    = (rd_state_q == RD_SEND) && i_char_ready;

   // State register (all flops)
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rd_state_q   <= RD_IDLE;
         prev_state_q <= '0;
         idx_q        <= '0;
         digits_q     <= '0;
         code_q       <= '0;
         result_ms_q  <= '0;
         attempts_q   <= '0;
      end else begin
         rd_state_q   <= rd_state_d;
         prev_state_q <= prev_state_d;
         idx_q        <= idx_d;
         digits_q     <= digits_d;
         code_q       <= code_d;
         result_ms_q  <= result_ms_d;
         attempts_q   <= attempts_d;
      end
   end

   // Next-state logic
   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         RD_IDLE: if (capture)                  rd_state_d = RD_SEND;
         RD_SEND: if (xfer && idx_q == 3'd4)    rd_state_d = RD_IDLE;
         default:                               rd_state_d = RD_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      prev_state_d = i_state;
      idx_d        = idx_q;
      digits_d     = digits_q;
      code_d       = code_q;
      result_ms_d  = result_ms_q;
      attempts_d   = attempts_q;
      if (accept) begin
         idx_d       = '0;
         digits_d    = {i_seg3, i_seg2, i_seg1, i_seg0};
         code_d      = i_fail_state;
         result_ms_d = live_ms;
         if (!(&attempts_q)) attempts_d = attempts_q + ATTEMPT_W'(1);
      end else if (xfer) begin
         idx_d = idx_q + 3'd1;
      end
   end

   // Outputs
   always_comb begin
      o_char_valid  = (rd_state_q == RD_SEND);
      o_busy        = o_char_valid;
      o_char        = o_char_valid ? msg_char(code_q, digits_q, idx_q) : 8'h00;
      o_char_last   = o_char_valid && (idx_q == 3'd4);
      o_result_ms   = result_ms_q;
      o_result_code = code_q;
      o_attempts    = attempts_q;
   end

`ifdef REACTION_BEST_TIME_EN
   logic [13:0] best_ms_q, best_ms_d;
   logic        best_valid_q, best_valid_d;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         best_ms_q    <= '0;
         best_valid_q <= 1'b0;
      end else begin
         best_ms_q    <= best_ms_d;
         best_valid_q <= best_valid_d;
      end
   end

   // Ties keep the existing record.
   always_comb begin
      best_ms_d    = best_ms_q;
      best_valid_d = best_valid_q;
      if (accept && i_fail_state == FAIL_NONE &&
          (!best_valid_q || live_ms < best_ms_q)) begin
         best_ms_d    = live_ms;
         best_valid_d = 1'b1;
      end
   end

   assign o_best_ms    = best_ms_q;
   assign o_best_valid = best_valid_q;
`else
   assign o_best_ms    = '0;
   assign o_best_valid = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_result_reader.sv
module tb_reaction_result_reader;

`ifdef REACTION_BEST_TIME_EN
   localparam bit BEST_EN = 1'b1;
`else
   localparam bit BEST_EN = 1'b0;
`endif

   logic        i_clk, i_reset_n;
   logic [1:0]  i_state, i_fail_state;
   logic [3:0]  i_seg3, i_seg2, i_seg1, i_seg0;
   logic        i_char_ready;
   logic        o_char_valid, o_char_last, o_busy, o_best_valid;
   logic [7:0]  o_char;
   logic [13:0] o_result_ms, o_best_ms;
   logic [1:0]  o_result_code;
   logic [7:0]  o_attempts;

   reaction_result_reader #(.ATTEMPT_W(8)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_state(i_state),
      .i_fail_state(i_fail_state), .i_seg3(i_seg3), .i_seg2(i_seg2),
      .i_seg1(i_seg1), .i_seg0(i_seg0), .i_char_ready(i_char_ready),
      .o_char_valid(o_char_valid), .o_char(o_char), .o_char_last(o_char_last),
      .o_busy(o_busy), .o_result_ms(o_result_ms), .o_result_code(o_result_code),
      .o_attempts(o_attempts), .o_best_ms(o_best_ms), .o_best_valid(o_best_valid)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int m_att = 0;
   int m_best = 0;
   bit m_bv = 1'b0;

   typedef struct {
      logic [3:0]  d3, d2, d1, d0;
      logic [1:0]  code;
      logic [3:0]  pat;
      logic [39:0] msg;
      int          ms;
      int          best;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int clamp(input logic [3:0] d);
      return (d > 9) ? 9 : int'(d);
   endfunction

   function automatic int model_ms(input logic [3:0] d3, d2, d1, d0);
      return clamp(d3) * 1000 + clamp(d2) * 100 + clamp(d1) * 10 + clamp(d0);
   endfunction

   function automatic logic [7:0] dch(input logic [3:0] d);
      return (d > 9) ? "?" : (8'h30 + {4'd0, d});
   endfunction

   function automatic logic [39:0] model_msg(input logic [1:0] code,
                                             input logic [3:0] d3, d2, d1, d0);
      case (code)
         2'd0:    return {dch(d3), ".", dch(d2), dch(d1), dch(d0)};
         2'd1:    return "EARLY";
         2'd2:    return "SLOW!";
         default: return "?????";
      endcase
   endfunction

   task automatic model_capture(input logic [1:0] code, input int ms);
      m_att = (m_att < 255) ? m_att + 1 : 255;
      if (BEST_EN && code == 2'd0 && (!m_bv || ms < m_best)) begin
         m_best = ms;
         m_bv   = 1'b1;
      end
   endtask

   // One round: enter react, then done; drain the message with the given
   // ready pattern (or random ready). Model must already be updated.
   task automatic run_round(input logic [3:0] d3, d2, d1, d0, input logic [1:0] code,
                            input logic [3:0] pat, input bit rnd, input bit glitch,
                            input logic [39:0] exp_msg, input int exp_ms,
                            input int exp_best, input bit exp_bv, input string name);
      logic [39:0] got;
      logic [7:0]  held_c;
      logic        held_l, stalled, r;
      int n, cyc;
      got = '0; n = 0; cyc = 0; stalled = 1'b0; held_c = '0; held_l = 1'b0;
      @(negedge i_clk);
      i_state = 2'd2; i_fail_state = code;
      i_seg3 = d3; i_seg2 = d2; i_seg1 = d1; i_seg0 = d0; i_char_ready = 1'b0;
      @(negedge i_clk);
      i_state = 2'd3;
      @(negedge i_clk);
      chk({name, " busy"}, o_busy, 1);
      chk({name, " valid"}, o_char_valid, 1);
      chk({name, " ms"}, o_result_ms, exp_ms);
      chk({name, " code"}, o_result_code, code);
      chk({name, " attempts"}, o_attempts, m_att);
      chk({name, " best_ms"}, o_best_ms, exp_best);
      chk({name, " best_valid"}, o_best_valid, exp_bv);
      // live digits no longer matter once captured
      {i_seg3, i_seg2, i_seg1, i_seg0} = 16'($urandom);
      while (n < 5 && cyc < 200) begin
         if (glitch && cyc == 1) i_state = 2'd0;
         if (glitch && cyc == 2) i_state = 2'd3;
         r = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
         i_char_ready = r;
         if (!o_char_valid) begin
            chk({name, " valid mid-msg"}, o_char_valid, 1);
            break;
         end
         if (stalled) chk({name, " stall hold"}, {o_char, o_char_last}, {held_c, held_l});
         if (r) begin
            got = {got[31:0], o_char};
            chk({name, " last"}, o_char_last, (n == 4));
            n++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held_c = o_char; held_l = o_char_last;
         end
         cyc++;
         @(negedge i_clk);
      end
      i_char_ready = 1'b0;
      chk({name, " count"}, n, 5);
      chk({name, " msg"}, got, exp_msg);
      chk({name, " valid end"}, o_char_valid, 0);
      chk({name, " busy end"}, o_busy, 0);
      chk({name, " attempts end"}, o_attempts, m_att);
      i_state = 2'd0;
   endtask

   initial begin
      logic [3:0] d3, d2, d1, d0;
      logic [1:0] c;
      int ms, eb;

      tbl[0] = '{4'd0, 4'd2, 4'd3, 4'd4, 2'd0, 4'hF, "0.234", 234,  234};
      tbl[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 2'd1, 4'b1001, "EARLY", 9999, 234};
      tbl[2] = '{4'd1, 4'd0, 4'd0, 4'd0, 2'd2, 4'hF, "SLOW!", 1000, 234};
      tbl[3] = '{4'd0, 4'd1, 4'd8, 4'd0, 2'd0, 4'b1001, "0.180", 180,  180};
      tbl[4] = '{4'd0, 4'd1, 4'd8, 4'd0, 2'd0, 4'hF, "0.180", 180,  180};
      tbl[5] = '{4'd0, 4'd3, 4'd0, 4'd0, 2'd0, 4'hF, "0.300", 300,  180};
      tbl[6] = '{4'hC, 4'd0, 4'd0, 4'd0, 2'd0, 4'hF, "?.000", 9000, 180};
      tbl[7] = '{4'd1, 4'd2, 4'd3, 4'd4, 2'd3, 4'b0101, "?????", 1234, 180};

      i_reset_n = 1'b0; i_state = '0; i_fail_state = '0;
      i_seg3 = '0; i_seg2 = '0; i_seg1 = '0; i_seg0 = '0; i_char_ready = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("reset valid", o_char_valid, 0);
      chk("reset busy", o_busy, 0);
      chk("reset attempts", o_attempts, 0);
      i_reset_n = 1'b1;
      @(negedge i_clk);
      chk("post-reset outputs",
          {o_char_valid, o_char, o_char_last, o_busy, o_result_ms, o_result_code,
           o_best_ms, o_best_valid}, 0);

      // directed table
      for (int i = 0; i < 8; i++) begin
         model_capture(tbl[i].code, tbl[i].ms);
         run_round(tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].d0, tbl[i].code,
                   tbl[i].pat, 1'b0, 1'b0, tbl[i].msg, tbl[i].ms,
                   BEST_EN ? tbl[i].best : 0, BEST_EN, $sformatf("tbl%0d", i));
      end

      // capture event while sending is dropped
      model_capture(2'd0, 400);
      run_round(4'd0, 4'd4, 4'd0, 4'd0, 2'd0, 4'b1001, 1'b0, 1'b1, "0.400", 400,
                BEST_EN ? 180 : 0, BEST_EN, "glitch");

      // random rounds against the model; enough to saturate attempts
      for (int i = 0; i < 260; i++) begin
         d3 = 4'($urandom_range(0, 15)); d2 = 4'($urandom_range(0, 15));
         d1 = 4'($urandom_range(0, 15)); d0 = 4'($urandom_range(0, 15));
         c  = 2'($urandom_range(0, 3));
         ms = model_ms(d3, d2, d1, d0);
         model_capture(c, ms);
         eb = m_best;
         run_round(d3, d2, d1, d0, c, 4'hF, (i < 40), 1'b0,
                   model_msg(c, d3, d2, d1, d0), ms, eb, m_bv,
                   $sformatf("rnd%0d", i));
      end
      chk("attempts saturated", o_attempts, 255);

      // reset in the middle of a message
      @(negedge i_clk);
      i_state = 2'd2; i_fail_state = 2'd0;
      i_seg3 = 4'd5; i_seg2 = 4'd6; i_seg1 = 4'd7; i_seg0 = 4'd8;
      @(negedge i_clk);
      i_state = 2'd3;
      @(negedge i_clk);
      i_char_ready = 1'b1;
      repeat (2) @(negedge i_clk);
      chk("pre-reset valid", o_char_valid, 1);
      #2 i_reset_n = 1'b0;
      #1;
      chk("async reset valid", o_char_valid, 0);
      chk("async reset outputs",
          {o_char, o_char_last, o_busy, o_result_ms, o_result_code, o_attempts,
           o_best_ms, o_best_valid}, 0);
      @(negedge i_clk);
      i_state = 2'd0; i_char_ready = 1'b0;
      @(negedge i_clk);
      i_reset_n = 1'b1;
      m_att = 0; m_best = 0; m_bv = 1'b0;
      model_capture(2'd0, 456);
      run_round(4'd0, 4'd4, 4'd5, 4'd6, 2'd0, 4'hF, 1'b0, 1'b0, "0.456", 456,
                m_best, m_bv, "after-reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reaction_result_reader.md
# reaction_result_reader

Consumer end of the reaction timer's result interface. Watches the timer's state, BCD digit and fail-code outputs, captures each finished round on entry to `done`, and converts the BCD reading to binary milliseconds. It streams a fixed 5-character ASCII result message to the OLED text writer over a valid/ready handshake. It also keeps an attempt counter and an optional best-time record.

## Interface
Parameters:
- `ATTEMPT_W`, 8: width of the saturating attempt counter.

Ports:
- `i_clk`, input, 1: system clock; all logic is in this single domain.
- `i_reset_n`, input, 1: asynchronous active-low reset.
- `i_state`, input, 2: timer state code (0 idle, 1 random_count, 2 react, 3 done).
- `i_fail_state`, input, 2: timer result code (0 success, 1 early, 2 slow, 3 reserved).
- `i_seg3`, `i_seg2`, `i_seg1`, `i_seg0`, input, 4 each: BCD digits; seg3 is the units of seconds, seg0 is ms.
- `i_char_ready`, input, 1: text writer accepts a character.
- `o_char_valid`, output, 1: `o_char` holds a valid character.
- `o_char`, output, 8: ASCII character.
- `o_char_last`, output, 1: marks the 5th character of the message.
- `o_busy`, output, 1: high while a message is pending or being sent.
- `o_result_ms`, output, 14: binary ms value of the last capture (0..9999).
- `o_result_code`, output, 2: fail code of the last capture.
- `o_attempts`, output, `ATTEMPT_W`: number of captures, saturating.
- `o_best_ms`, output, 14: smallest successful result.
- `o_best_valid`, output, 1: `o_best_ms` holds a real value.

## Operation
- Reset values: every output and register is 0; the FSM is in IDLE. Reset is asynchronous, so `o_char_valid` drops the moment `i_reset_n` goes low, including mid-message.
- A registered copy of `i_state` gives `prev_state`. The capture event is `i_state==3 && prev_state!=3`.
- FSM states:
  - IDLE: on a capture event, latch the four digits and the fail code into the message registers, update `o_result_ms`, `o_result_code`, `o_attempts` and best, set index to 0, and go to SEND.
  - SEND: present `msg[index]`. On `o_char_valid && i_char_ready`, increment index. A transfer at index 4 returns to IDLE.
- Capture events that occur in SEND are dropped: no latch, no attempt increment.
- Messages (always 5 characters):
  - Code 0: `d3 '.' d2 d1 d0` as ASCII digits (0x30 + d).
  - Code 1: "EARLY".
  - Code 2: "SLOW!".
  - Code 3: "?????".
- Invalid BCD digit (>9): shown as '?' (0x3F) and treated as 9 in the arithmetic.
- Arithmetic: `ms = d3*1000 + d2*100 + d1*10 + d0`, 14 bits unsigned, computed combinationally from the live inputs and registered at capture. `o_result_ms` is updated for every code, including fails.
- `o_attempts` increments on every accepted capture and holds at all-ones.
- Best time, updated only on code 0 captures: replace when `!o_best_valid` or `ms < o_best_ms`. An equal value leaves it unchanged. `o_best_valid` is set on the first update.

## Timing
- Capture event sampled at edge N; `o_char_valid`=1 and the first character appear after edge N. `o_busy` is high from edge N onward.
- Handshake rules:
  - While `o_char_valid && !i_char_ready`, `o_char` and `o_char_last` are held stable.
  - `o_char_valid` never deasserts mid-message except on reset.
  - With `i_char_ready` held high, one character transfers per cycle, so the whole message takes 5 cycles.
  - `o_char_valid` and `o_busy` fall after the edge on which the last character transfers.
- Earliest next capture: the cycle after `o_busy` falls.
- `o_result_ms`, `o_result_code`, `o_attempts` and best are all updated at edge N and are stable during SEND.

## Configuration
- `REACTION_BEST_TIME_EN` defined: best-time comparator and registers are compiled in and behave as described above.
- Not defined: no best-time logic is built. `o_best_ms` is tied to 0 and `o_best_valid` to 0. All other behaviour is identical.

## Structure
- Shared package `reaction_pkg`:
  - Timer state codes (`ST_IDLE`, `ST_RANDOM`, `ST_REACT`, `ST_DONE`).
  - Fail codes (`FAIL_NONE`, `FAIL_EARLY`, `FAIL_SLOW`).
  - `MSG_LEN`=5.
  - ASCII constants for '0', '.', '?' and the fixed message strings.
- One sub-module, `bcd4_to_bin`: combinational 4-digit BCD to 14-bit binary with the invalid-digit-as-9 clamp.

## Test plan
- **Success:** digits 0,2,3,4, code 0, state 2→3, ready high → chars 0x30,0x2E,0x32,0x33,0x34 on 5 consecutive cycles, last on the 5th; `o_result_ms`=234; `o_attempts`=1; best=234, valid=1.
- **Backpressure:** same round with ready toggling 1,0,0,1,… → no character lost or duplicated, and `o_char` is stable during the stalls.
- **Failures:** code 1 with digits 9999 → "EARLY", `o_result_ms`=9999, best unchanged. Code 2 with digits 1000 → "SLOW!", `o_result_ms`=1000.
- **Best tracking:** successes of 234, then 180, then 180, then 300 → `o_best_ms`=234, 180, 180, 180. With the macro off, `o_best_valid` stays 0.
- **Boundaries:**
  - Capture event during SEND → ignored and attempts unchanged.
  - 256 captures with `ATTEMPT_W`=8 → `o_attempts`=255.
  - Digit 0xC → '?' in the message and 9 in `o_result_ms`.
- **Reset mid-message:** `i_reset_n` low after the 2nd transfer → `o_char_valid`=0 immediately and all outputs 0. After release, a new round sends a full message from index 0.
